// File: rtl/multdiv.sv
// -----------------------------------------------------------------------------
// multdiv - multi-cycle signed 32-bit multiply / divide unit
//
// This unit sits beside the single-cycle ALU and executes mul and div. A
// one-cycle ctrl_MULT or ctrl_DIV pulse starts an operation. The unit then
// runs for 32 iterations and one sign-fix cycle. It reports completion with a
// one-cycle data_resultRDY strobe exactly 33 edges after the start edge.
//
// Ports
//   clock           in   1   rising-edge clock
//   reset           in   1   asynchronous, active-high reset
//   data_operandA   in  32   signed multiplicand / dividend (sampled at start)
//   data_operandB   in  32   signed multiplier / divisor    (sampled at start)
//   ctrl_MULT       in   1   start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   1   start pulse, divide
//   data_result     out 32   product low word or quotient (registered, held)
//   data_exception  out  1   multiply overflow, divide overflow or divide by 0
//   data_resultRDY  out  1   one-cycle result-valid strobe
// -----------------------------------------------------------------------------
module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;      // iterations completed, 0..32
    logic [63:0] acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd_q, opnd_d;    // |B|: multiplicand or divisor
    logic        neg_q, neg_d;      // result sign for the final fix-up
    logic        bzero_q, bzero_d;  // divide by zero
    logic        dovf_q, dovf_d;    // 0x80000000 / -1
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    // Operand magnitudes. |0x80000000| = 0x80000000 remains correct as an unsigned value.
    logic [31:0] mag_a, mag_b;
    assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

    // Shift-add step: add the multiplicand into the high half when the multiplier LSB is set,
    // then shift right. The carry out of the add becomes the new MSB.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring step: shift the next dividend bit into the remainder, then try to subtract.
    // The remainder is always below the divisor (at most 2^31), so 33 bits hold the shifted value.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    assign div_shift = acc_q[63:31];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_next  = div_diff[33] ? {acc_q[62:0], 1'b0}
                                    : {div_diff[31:0], acc_q[30:0], 1'b1};

    // Signed results after the sign fix.
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic        mul_ovf;
    assign prod_s  = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo_s   = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    // The product fits in 32 signed bits only if bits 63..31 are all equal.
    assign mul_ovf = ~((&prod_s[63:31]) | ~(|prod_s[63:31]));

    always_comb begin
        // NOTE: every signal is given a default first, so no path leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        dovf_d   = dovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        unique case (state_q)
            S_IDLE: ;
            S_MUL: begin
                if (cnt_q == 6'd32) begin
                    state_d  = S_DONE;
                    result_d = prod_s[31:0];
                    exc_d    = mul_ovf;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 6'd32) begin
                    state_d = S_DONE;
                    if (bzero_q) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        // 0x80000000 / -1 already yields 0x80000000; only the flag differs.
                        result_d = quo_s;
                        exc_d    = dovf_q;
                    end
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A start pulse overrides everything, including an operation in flight.
        if (ctrl_MULT || ctrl_DIV) begin
            state_d = ctrl_MULT ? S_MUL : S_DIV;
            cnt_d   = 6'd0;
            acc_d   = {32'd0, mag_a};
            opnd_d  = mag_b;
            neg_d   = data_operandA[31] ^ data_operandB[31];
            bzero_d = (data_operandB == 32'd0);
            dovf_d  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_multdiv.sv
// -----------------------------------------------------------------------------
// tb_multdiv - directed self-checking bench for multdiv.
// It checks latency, result values, exception flags, restart and priority
// behaviour, and asynchronous reset against hand-computed values.
// -----------------------------------------------------------------------------
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_cmp  = 0;
    int n_fail = 0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a start pulse onto the next rising edge. On return we are 1 time unit past that edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Operands may change freely after the start edge.
        data_operandA = $urandom;
        data_operandB = $urandom;
        check("rdy_low_after_start", {31'd0, data_resultRDY}, 32'd0);
    endtask

    // Count edges after the start edge until the strobe appears. Give up after 80 edges.
    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 80);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d,
                          input logic [31:0] exp_res, input logic exp_exc);
        int n;
        start(a, b, m, d);
        wait_rdy(n);
        check({tag, "_lat"}, 32'(n), 32'd33);
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_res", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Multiply. The second start arrives on the edge that leaves DONE (back-to-back).
        run_op("mul_6x7",   32'd6,          32'd7,  1'b1, 1'b0, 32'd42,         1'b0);
        run_op("mul_m6x7",  32'hFFFF_FFFA,  32'd7,  1'b1, 1'b0, 32'hFFFF_FFD6,  1'b0);
        @(posedge clock); #1;
        check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
        check("hold_res", data_result, 32'hFFFF_FFD6);
        run_op("mul_ovf16", 32'h0001_0000,  32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
        run_op("mul_ovfmax",32'h7FFF_FFFF,  32'd2,  1'b1, 1'b0, 32'hFFFF_FFFE,  1'b1);

        // Divide.
        run_op("div_m7d2",  32'hFFFF_FFF9,  32'd2,          1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_100dm7",32'd100,        32'hFFFF_FFF9,  1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0);
        run_op("div_3d5",   32'd3,          32'd5,          1'b0, 1'b1, 32'd0,         1'b0);
        run_op("div_by0",   32'd5,          32'd0,          1'b0, 1'b1, 32'd0,         1'b1);
        run_op("div_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000, 1'b1);

        // Restart: a DIV issued 10 edges into a MUL aborts the MUL and completes 33 edges later.
        start(32'd6, 32'd7, 1'b1, 1'b0);
        n = 0;
        repeat (9) begin
            @(posedge clock); #1;
            if (data_resultRDY) n++;
        end
        check("restart_no_early_rdy", 32'(n), 32'd0);
        run_op("restart_div", 32'd20, 32'd4, 1'b0, 1'b1, 32'd5, 1'b0);

        // When both start pulses are high, the multiply wins.
        run_op("both_mul", 32'd20, 32'd4, 1'b1, 1'b1, 32'd80, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        start(32'd6, 32'd7, 1'b1, 1'b0);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_res", data_result, 32'd0);
        check("arst_exc", {31'd0, data_exception}, 32'd0);
        check("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) n++;
        end
        check("arst_no_rdy", 32'(n), 32'd0);
        run_op("post_rst_3x3", 32'd3, 32'd3, 1'b1, 1'b0, 32'd9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
